alu_exec: RTL and testbench
===========================

Name: alu_exec

Overview:
- Execute stage that consumes the 4-bit ALU operation code produced by the opcode decoder, plus two operands.
- Returns a registered result, flags and a branch-taken indication over a valid/ready handshake.
- Single-cycle ops finish in one cycle. Shifts run iteratively, one bit per cycle.
- One operation is in flight at a time. Sits between decode/register-read and writeback/PC-select.

Parameters:
- WIDTH, 8, datapath width in bits. Must be a power of two and at least 4.
- SHW, $clog2(WIDTH), shift-amount width. Derived; not overridable.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operation presented
- in_ready  output  1  stage can accept an operation this cycle
- alu_inst  input  4  ALU op code: ADD=0, SUB=1, SFL=2, SFR=3, INC=4, DEC=5, BNE=6, BEQ=7, BLT=8
- op_a  input  WIDTH  operand A
- op_b  input  WIDTH  operand B; low SHW bits are the shift amount for SFL/SFR
- flush  input  1  synchronous abort of the in-flight op
- out_valid  output  1  result registers valid
- out_ready  input  1  consumer accepts the result
- result  output  WIDTH  result value
- carry  output  1  ADD/INC carry-out; SUB/DEC/branch borrow (A<B unsigned); 0 for shifts
- zero  output  1  result == 0
- taken  output  1  branch condition true (branch ops only, else 0)
- illegal  output  1  alu_inst outside 0..8

Behaviour:
- Reset values: all outputs 0, except in_ready = 1. State = IDLE.
- Accept occurs when in_valid && in_ready. Operands and op are captured on that edge.
- States:
  - IDLE: in_ready = 1. On accept of a non-shift op, or a shift with amount 0, go to HOLD with results registered. On accept of a shift with amount k > 0, go to SHIFT with count = k and the working register = op_a.
  - SHIFT: in_ready = 0. Each cycle, shift the working register by 1 (SFL: logical left; SFR: logical right, zero-fill) and decrement count. When count reaches 1, the final shift is taken, flags are computed, and the state moves to HOLD.
  - HOLD: out_valid = 1. Outputs stay stable until out_ready. On out_ready, go to IDLE; in_ready = out_ready in HOLD, so a new accept in the same cycle goes straight to its next state (back-to-back, 1 op/cycle for non-shift ops).
- Latency, for an accept at edge N:
  - Non-shift: out_valid at N+1.
  - Shift by k: out_valid at N+1+k.
- Arithmetic: all results are mod 2^WIDTH.
  - ADD: A+B, carry = bit WIDTH.
  - SUB: A-B, carry = borrow.
  - INC: A+1, carry = (A == all-ones).
  - DEC: A-1, carry = (A == 0).
- Branches (BNE, BEQ, BLT): result = A-B, carry = borrow.
  - BNE: taken = (A != B).
  - BEQ: taken = (A == B).
  - BLT: taken = (A < B), unsigned.
- Illegal op (9..15): accepted like a single-cycle op. result = 0, zero = 1, carry = 0, taken = 0, illegal = 1. The op is never dropped or stalled.
- Flush: takes priority over everything except reset. In any state, go to IDLE next edge with out_valid = 0. An accept in the flush cycle is ignored.
- Reset mid-op: asynchronous return to reset values; no partial result is emitted.
- in_ready never depends combinationally on in_valid. out_valid never depends combinationally on out_ready.

Decomposition:
- Shared package alu_pkg holds:
  - the ALU op code constants (shared with the decoder);
  - the state enum (IDLE, SHIFT, HOLD);
  - a typedef for the flag bundle (carry, zero, taken, illegal).
- One sub-module: alu_exec_core. It is combinational and computes result and flags for all non-shift ops from (alu_inst, op_a, op_b). alu_exec owns the FSM, handshake and shift iteration.

Test Plan:
- ADD 0xF0 + 0x20 with out_ready held 1 -> next cycle: result = 0x10, carry = 1, zero = 0, out_valid pulse of 1 cycle.
- SFL A = 0x81, B = 3 -> in_ready low 3 cycles, out_valid at accept+4: result = 0x08, carry = 0. Then SFR A = 0x80, B = 0 -> result = 0x80, latency 1.
- BLT A = 0x05, B = 0x07 -> taken = 1, carry = 1, result = 0xFE. BEQ 0x33/0x33 -> taken = 1, zero = 1. BNE 0x33/0x33 -> taken = 0.
- Back-pressure: SUB 0x00 - 0x01 with out_ready = 0 for 5 cycles -> result = 0xFF and carry = 1 held stable, in_ready = 0. A new INC 0xFF offered in the out_ready cycle is accepted -> next result = 0x00, carry = 1, zero = 1.
- alu_inst = 0xB -> illegal = 1, result = 0, zero = 1, latency 1. DEC 0x00 -> 0xFF, carry = 1.
- Flush during SFR by 7 (cycle 3) -> IDLE next edge, out_valid never asserts. Separately, rst_n low mid-SHIFT -> all outputs 0 and in_ready = 1 immediately.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU execute stage: op codes (also used by the
// opcode decoder), FSM state encoding and the flag bundle.
package alu_pkg;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_SFL = 4'd2;
  localparam logic [3:0] ALU_SFR = 4'd3;
  localparam logic [3:0] ALU_INC = 4'd4;
  localparam logic [3:0] ALU_DEC = 4'd5;
  localparam logic [3:0] ALU_BNE = 4'd6;
  localparam logic [3:0] ALU_BEQ = 4'd7;
  localparam logic [3:0] ALU_BLT = 4'd8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_HOLD
  } state_t;

  typedef struct packed {
    logic carry;
    logic zero;
    logic taken;
    logic illegal;
  } flags_t;

  function automatic logic is_shift(input logic [3:0] op);
    return (op == ALU_SFL) || (op == ALU_SFR);
  endfunction

endpackage

// File: rtl/alu_exec_core.sv
// Combinational result and flag computation for every single-cycle op.
// Shifts are only passed through here (amount-0 case); the top iterates them.
module alu_exec_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [3:0]       alu_inst,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero,
  output logic             taken,
  output logic             illegal
);

  localparam logic [WIDTH:0] ONE = (WIDTH+1)'(1);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;
  logic [WIDTH:0] inc;
  logic [WIDTH:0] dec;

  // The extra top bit carries out of ADD/INC and holds the borrow of SUB/DEC.
  assign sum  = {1'b0, op_a} + {1'b0, op_b};
  assign diff = {1'b0, op_a} - {1'b0, op_b};
  assign inc  = {1'b0, op_a} + ONE;
  assign dec  = {1'b0, op_a} - ONE;

  always_comb begin
    // NOTE: every output gets a default before the case so no path can infer a latch.
    result  = '0;
    carry   = 1'b0;
    taken   = 1'b0;
    illegal = 1'b0;
    case (alu_inst)
      ALU_ADD: begin
        result = sum[WIDTH-1:0];
        carry  = sum[WIDTH];
      end
      ALU_SUB: begin
        result = diff[WIDTH-1:0];
        carry  = diff[WIDTH];
      end
      ALU_SFL, ALU_SFR: result = op_a;
      ALU_INC: begin
        result = inc[WIDTH-1:0];
        carry  = inc[WIDTH];
      end
      ALU_DEC: begin
        result = dec[WIDTH-1:0];
        carry  = dec[WIDTH];
      end
      ALU_BNE, ALU_BEQ, ALU_BLT: begin
        result = diff[WIDTH-1:0];
        carry  = diff[WIDTH];
        if (alu_inst == ALU_BNE)      taken = (op_a != op_b);
        else if (alu_inst == ALU_BEQ) taken = (op_a == op_b);
        else                          taken = diff[WIDTH];
      end
      default: illegal = 1'b1;
    endcase
    zero = (result == '0);
  end

endmodule

// File: rtl/alu_exec.sv
// ALU execute stage: valid/ready handshake, one op in flight, single-cycle
// ops via alu_exec_core and bit-serial shifts (one position per cycle).
module alu_exec
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_inst,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero,
  output logic             taken,
  output logic             illegal
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW-1:0] CNT_ONE = SHW'(1);

  state_t           state;
  logic [SHW-1:0]   count;
  logic [WIDTH-1:0] work;
  logic             shift_left;
  flags_t           flags_q;

  logic [WIDTH-1:0] core_result;
  logic             core_carry;
  logic             core_zero;
  logic             core_taken;
  logic             core_illegal;
  logic [WIDTH-1:0] work_next;
  logic [SHW-1:0]   shift_amt;
  logic             accept;

  alu_exec_core #(.WIDTH(WIDTH)) u_core (
    .alu_inst (alu_inst),
    .op_a     (op_a),
    .op_b     (op_b),
    .result   (core_result),
    .carry    (core_carry),
    .zero     (core_zero),
    .taken    (core_taken),
    .illegal  (core_illegal)
  );

  // HOLD frees up in the same cycle the consumer takes the result.
  assign in_ready  = (state == ST_IDLE) || ((state == ST_HOLD) && out_ready);
  assign accept    = in_valid && in_ready;
  assign shift_amt = op_b[SHW-1:0];
  assign work_next = shift_left ? (work << 1) : (work >> 1);

  assign carry   = flags_q.carry;
  assign zero    = flags_q.zero;
  assign taken   = flags_q.taken;
  assign illegal = flags_q.illegal;

  // NOTE: state updates use non-blocking assignments; rst_n is asynchronous and clears everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      count      <= '0;
      work       <= '0;
      shift_left <= 1'b0;
      out_valid  <= 1'b0;
      result     <= '0;
      flags_q    <= '0;
    end else if (flush) begin
      state     <= ST_IDLE;
      out_valid <= 1'b0;
    end else begin
      case (state)
        ST_SHIFT: begin
          work  <= work_next;
          count <= count - CNT_ONE;
          if (count == CNT_ONE) begin
            state     <= ST_HOLD;
            out_valid <= 1'b1;
            result    <= work_next;
            flags_q   <= '{carry: 1'b0, zero: (work_next == '0), taken: 1'b0, illegal: 1'b0};
          end
        end
        default: begin
          if (accept) begin
            if (is_shift(alu_inst) && (shift_amt != '0)) begin
              state      <= ST_SHIFT;
              work       <= op_a;
              count      <= shift_amt;
              shift_left <= (alu_inst == ALU_SFL);
              out_valid  <= 1'b0;
            end else begin
              state     <= ST_HOLD;
              out_valid <= 1'b1;
              result    <= core_result;
              flags_q   <= '{carry: core_carry, zero: core_zero,
                             taken: core_taken, illegal: core_illegal};
            end
          end else if (out_ready) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec.sv
// Self-checking bench for alu_exec: transaction-level model compared every
// cycle, plus directed vectors with hand-computed literal results.
module tb_alu_exec;

  localparam int W   = 8;
  localparam int MOD = 1 << W;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [3:0]   alu_inst = 4'd0;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic         flush = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] result;
  logic         carry, zero, taken, illegal;

  always #5 clk = ~clk;

  alu_exec #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_inst  (alu_inst),
    .op_a      (op_a),
    .op_b      (op_b),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carry     (carry),
    .zero      (zero),
    .taken     (taken),
    .illegal   (illegal)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    int r;
    bit c;
    bit z;
    bit t;
    bit i;
  } exp_t;

  // Expected outcome straight from the op definitions, in plain integer arithmetic.
  function automatic exp_t model_op(input int op, input int a, input int b);
    exp_t e;
    e = '{r: 0, c: 1'b0, z: 1'b0, t: 1'b0, i: 1'b0};
    case (op)
      0: begin e.r = (a + b) % MOD; e.c = (a + b) >= MOD; end
      1, 6, 7, 8: begin
        e.r = (a - b + MOD) % MOD;
        e.c = a < b;
        if (op == 6) e.t = a != b;
        if (op == 7) e.t = a == b;
        if (op == 8) e.t = a < b;
      end
      2: e.r = (a << (b % W)) % MOD;
      3: e.r = a >> (b % W);
      4: begin e.r = (a + 1) % MOD; e.c = a == MOD - 1; end
      5: begin e.r = (a + MOD - 1) % MOD; e.c = a == 0; end
      default: e.i = 1'b1;
    endcase
    e.z = e.r == 0;
    return e;
  endfunction

  // Model: one outstanding op, visible from edge count 'vis' until consumed.
  bit   busy = 1'b0;
  int   cyc = 0;
  int   vis = 0;
  exp_t m_exp;

  always @(posedge clk or negedge rst_n) begin
    bit mv, mr;
    int k;
    if (!rst_n) begin
      busy = 1'b0;
    end else begin
      mv = busy && (cyc >= vis);
      mr = !busy || (mv && out_ready);
      cyc++;
      if (flush) begin
        busy = 1'b0;
      end else begin
        if (mv && out_ready) busy = 1'b0;
        if (in_valid && mr) begin
          k     = (alu_inst == 4'd2 || alu_inst == 4'd3) ? int'(op_b) % W : 0;
          busy  = 1'b1;
          vis   = cyc + k;
          m_exp = model_op(int'(alu_inst), int'(op_a), int'(op_b));
        end
      end
    end
  end

  always @(negedge clk) begin
    bit exp_v;
    #2;
    if (rst_n) begin
      exp_v = busy && (cyc >= vis);
      check("cmp_in_ready", in_ready, !busy || (exp_v && out_ready));
      check("cmp_out_valid", out_valid, exp_v);
      if (exp_v) begin
        check("cmp_result", result, m_exp.r);
        check("cmp_carry", carry, m_exp.c);
        check("cmp_zero", zero, m_exp.z);
        check("cmp_taken", taken, m_exp.t);
        check("cmp_illegal", illegal, m_exp.i);
      end
    end
  end

  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    in_valid = 1'b1;
    alu_inst = op;
    op_a     = a;
    op_b     = b;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Called right after issue(); lat counts cycles until out_valid (1 = next cycle).
  task automatic expect_out(input string name, input int lat, input logic [W-1:0] r,
                            input bit c, input bit z, input bit t, input bit i);
    int n = 1;
    #1;
    while (!out_valid && n < 40) begin
      @(negedge clk);
      #1;
      n++;
    end
    check({name, "_latency"}, n, lat);
    check({name, "_result"}, result, r);
    check({name, "_carry"}, carry, c);
    check({name, "_zero"}, zero, z);
    check({name, "_taken"}, taken, t);
    check({name, "_illegal"}, illegal, i);
  endtask

  task automatic check_all_reset(input string name);
    check({name, "_in_ready"}, in_ready, 1);
    check({name, "_out_valid"}, out_valid, 0);
    check({name, "_result"}, result, 0);
    check({name, "_flags"}, {carry, zero, taken, illegal}, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    #1 check_all_reset("reset");
    @(negedge clk);
    rst_n = 1'b1;

    issue(4'd0, 8'hF0, 8'h20);
    expect_out("add", 1, 8'h10, 1, 0, 0, 0);
    @(negedge clk);
    #1 check("add_pulse", out_valid, 0);

    issue(4'd2, 8'h81, 8'h03);
    #1 check("sfl_busy", in_ready, 0);
    expect_out("sfl", 4, 8'h08, 0, 0, 0, 0);
    issue(4'd3, 8'h80, 8'h00);
    expect_out("sfr0", 1, 8'h80, 0, 0, 0, 0);

    issue(4'd8, 8'h05, 8'h07);
    expect_out("blt", 1, 8'hFE, 1, 0, 1, 0);
    issue(4'd7, 8'h33, 8'h33);
    expect_out("beq", 1, 8'h00, 0, 1, 1, 0);
    issue(4'd6, 8'h33, 8'h33);
    expect_out("bne", 1, 8'h00, 0, 1, 0, 0);

    @(negedge clk);
    out_ready = 1'b0;
    issue(4'd1, 8'h00, 8'h01);
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp_result", result, 8'hFF);
      check("bp_carry", carry, 1);
      check("bp_in_ready", in_ready, 0);
      check("bp_out_valid", out_valid, 1);
      @(negedge clk);
    end
    out_ready = 1'b1;
    in_valid  = 1'b1;
    alu_inst  = 4'd4;
    op_a      = 8'hFF;
    op_b      = 8'h00;
    @(negedge clk);
    in_valid = 1'b0;
    expect_out("inc", 1, 8'h00, 1, 1, 0, 0);

    issue(4'hB, 8'h12, 8'h34);
    expect_out("illegal", 1, 8'h00, 0, 1, 0, 1);
    issue(4'd5, 8'h00, 8'h00);
    expect_out("dec", 1, 8'hFF, 1, 0, 0, 0);
    issue(4'd0, 8'hFF, 8'h01);
    expect_out("add_wrap", 1, 8'h00, 1, 1, 0, 0);

    // Flush in the third shift cycle, then a flush that collides with an accept in IDLE.
    issue(4'd3, 8'hFF, 8'h07);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1 check("flush_no_valid", out_valid, 0);
      @(negedge clk);
      if (i == 3) begin
        flush    = 1'b1;
        in_valid = 1'b1;
        alu_inst = 4'd0;
        op_a     = 8'h01;
        op_b     = 8'h01;
      end else begin
        flush    = 1'b0;
        in_valid = 1'b0;
      end
    end

    issue(4'd2, 8'h01, 8'h07);
    @(negedge clk);
    #3 rst_n = 1'b0;
    #1 check_all_reset("midshift_reset");
    @(negedge clk);
    rst_n = 1'b1;
    issue(4'd0, 8'h01, 8'h02);
    expect_out("after_reset", 1, 8'h03, 0, 0, 0, 0);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
